// File: rtl/led_blink_pkg.sv
// Shared types, register addresses and CFG field positions for the LED blink array.
package led_blink_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        BURST = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        CH_LOW,
        CH_HIGH,
        CH_DONE
    } chan_state_t;

    localparam logic [4:0] ADDR_CTRL   = 5'd16;
    localparam logic [4:0] ADDR_STATUS = 5'd17;

    localparam int CFG_MODE_LSB    = 16;
    localparam int CFG_MODE_MSB    = 17;
    localparam int CFG_BURST_LSB   = 20;
    localparam int CFG_BURST_MSB   = 27;
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_SYNC_BIT   = 1;
    localparam int STATUS_DONE_LSB = 16;

    function automatic led_mode_t cfg_mode(input logic [31:0] word);
        return led_mode_t'(word[CFG_MODE_MSB:CFG_MODE_LSB]);
    endfunction

endpackage

// File: rtl/led_blink_array_if.sv
// MMIO slot bus of the LED blink array; master drives strobes, slave returns rd_data.
interface led_blink_array_if;

    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);

endinterface

// File: rtl/led_blink_chan.sv
// One LED channel: holds its CFG register, half-period counter, edge counter and led state.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] wr_period,
    input  led_mode_t        wr_mode,
    input  logic [7:0]       wr_burst,
    output logic [CNT_W-1:0] period,
    output led_mode_t        mode,
    output logic [7:0]       burst,
    output logic             led,
    output logic             done
);

    chan_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, period_n;
    logic [8:0]       edges, edges_n, edges_inc;
    led_mode_t        mode_n;
    logic [7:0]       burst_n;
    logic             last_cnt;
    chan_state_t      toggled;

    assign last_cnt  = (cnt == period - CNT_W'(1));
    assign edges_inc = edges + 9'd1;
    assign toggled   = (state == CH_HIGH) ? CH_LOW : CH_HIGH;

    // NOTE: the CFG fields are plain flops, so they are reset like every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= CH_LOW;
            cnt    <= '0;
            edges  <= '0;
            period <= '0;
            mode   <= OFF;
            burst  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state  <= state_n;
            cnt    <= cnt_n;
            edges  <= edges_n;
            period <= period_n;
            mode   <= mode_n;
            burst  <= burst_n;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_n  = state;
        cnt_n    = cnt;
        edges_n  = edges;
        period_n = period;
        mode_n   = mode;
        burst_n  = burst;

        if (cfg_we) begin
            period_n = wr_period;
            mode_n   = wr_mode;
            burst_n  = wr_burst;
            cnt_n    = '0;
            edges_n  = '0;
            state_n  = (wr_mode == ON) ? CH_HIGH : CH_LOW;
        end else if (sync) begin
            cnt_n   = '0;
            edges_n = '0;
            if (mode == BLINK || mode == BURST) state_n = CH_LOW;
        end else if (tick) begin
            unique case (mode)
                BLINK: begin
                    if (period == '0) begin
                        state_n = CH_LOW;
                        cnt_n   = '0;
                    end else if (last_cnt) begin
                        state_n = toggled;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                BURST: begin
                    if (state == CH_DONE) begin
                        state_n = CH_DONE;
                    end else if (burst == '0) begin
                        state_n = CH_DONE;
                    end else if (period == '0) begin
                        state_n = CH_LOW;
                        cnt_n   = '0;
                    end else if (last_cnt) begin
                        cnt_n   = '0;
                        edges_n = edges_inc;
                        // The 2*B-th toggle lands on led = 0, which is where the burst parks.
                        state_n = (edges_inc == {burst, 1'b0}) ? CH_DONE : toggled;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign led  = (state == CH_HIGH);
    assign done = (state == CH_DONE);

endmodule

// File: rtl/led_blink_array.sv
// Multi-channel LED blink core: shared tick prescaler, CTRL/STATUS registers, MMIO decode.
module led_blink_array
    import led_blink_pkg::*;
#(
    parameter int W        = 8,
    parameter int N_CH     = 4,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    led_blink_array_if.slave        bus,
    output logic [W-1:0]            dout
);

    localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic             enable;
    logic [PSC_W-1:0] psc;
    logic             tick;
    logic             wr_en;
    logic             ctrl_we;
    logic             sync;
    logic [31:0]      rd_data;
    logic             unused_bus;

    logic [CNT_W-1:0] ch_period [N_CH];
    led_mode_t        ch_mode   [N_CH];
    logic [7:0]       ch_burst  [N_CH];
    logic [N_CH-1:0]  ch_led;
    logic [N_CH-1:0]  ch_done;

    assign wr_en      = bus.cs && bus.write;
    assign ctrl_we    = wr_en && (bus.addr == ADDR_CTRL);
    assign sync       = ctrl_we && bus.wr_data[CTRL_SYNC_BIT];
    assign tick       = enable && (psc == PSC_W'(TICK_DIV - 1));
    assign unused_bus = ^{bus.read, bus.wr_data};

    // The enable in effect before the edge decides whether this edge advances the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            psc    <= '0;
        end else begin
            if (ctrl_we) enable <= bus.wr_data[CTRL_EN_BIT];
            if (sync)
                psc <= '0;
            else if (enable)
                psc <= tick ? '0 : psc + PSC_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        led_blink_chan #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .sync      (sync),
            .cfg_we    (wr_en && (bus.addr == 5'(i))),
            .wr_period (bus.wr_data[CNT_W-1:0]),
            .wr_mode   (cfg_mode(bus.wr_data)),
            .wr_burst  (bus.wr_data[CFG_BURST_MSB:CFG_BURST_LSB]),
            .period    (ch_period[i]),
            .mode      (ch_mode[i]),
            .burst     (ch_burst[i]),
            .led       (ch_led[i]),
            .done      (ch_done[i])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.addr == 5'(i)) begin
                rd_data[CNT_W-1:0]                   = ch_period[i];
                rd_data[CFG_MODE_MSB:CFG_MODE_LSB]   = ch_mode[i];
                rd_data[CFG_BURST_MSB:CFG_BURST_LSB] = ch_burst[i];
            end
        end
        if (bus.addr == ADDR_CTRL) rd_data[CTRL_EN_BIT] = enable;
        if (bus.addr == ADDR_STATUS) begin
            rd_data[N_CH-1:0]                 = ch_led;
            rd_data[STATUS_DONE_LSB +: N_CH]  = ch_done;
        end
    end

    assign bus.rd_data = rd_data;

    always_comb begin
        dout           = '0;
        dout[N_CH-1:0] = ch_led;
    end

endmodule

// File: tb/tb_led_blink_array.sv
// Randomised scoreboard bench for led_blink_array against a behavioural register/LED model.
module tb_led_blink_array;

    localparam int W        = 8;
    localparam int N_CH     = 4;
    localparam int CNT_W    = 16;
    localparam int TICK_DIV = 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] dout;

    led_blink_array_if bus ();

    led_blink_array #(
        .W(W), .N_CH(N_CH), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_dout_q [$];
    logic [31:0] exp_rd_q   [$];
    logic [4:0]  exp_addr_q [$];

    // Reference model: what the spec says the block holds after each clock edge.
    logic [31:0] m_cfg   [N_CH];
    int          m_cnt   [N_CH];
    int          m_edges [N_CH];
    bit          m_led   [N_CH];
    bit          m_done  [N_CH];
    bit          m_en;
    int          m_psc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_cfg(input int mode, input int p, input int b);
        logic [31:0] w;
        w = '0;
        w[15:0]  = 16'(p);
        w[17:16] = 2'(mode);
        w[27:20] = 8'(b);
        return w;
    endfunction

    task automatic model_reset();
        m_en  = 1'b0;
        m_psc = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_cfg[i]   = '0;
            m_cnt[i]   = 0;
            m_edges[i] = 0;
            m_led[i]   = 1'b0;
            m_done[i]  = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        if (int'(a) < N_CH) r = m_cfg[a];
        else if (a == 5'd16) r[0] = m_en;
        else if (a == 5'd17)
            for (int i = 0; i < N_CH; i++) begin
                r[i]      = m_led[i];
                r[16 + i] = m_done[i];
            end
        return r;
    endfunction

    function automatic logic [31:0] model_dout();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) r[i] = m_led[i];
        return r;
    endfunction

    task automatic model_edge(input bit wr, input logic [4:0] a, input logic [31:0] d);
        bit tick_now;
        bit sync_now;
        tick_now = m_en && (m_psc == TICK_DIV - 1);
        sync_now = wr && (a == 5'd16) && d[1];
        if (sync_now) m_psc = 0;
        else if (m_en) m_psc = (m_psc + 1) % TICK_DIV;
        if (wr && a == 5'd16) m_en = d[0];
        for (int i = 0; i < N_CH; i++) begin
            int mode;
            int p;
            int b;
            mode = int'(m_cfg[i][17:16]);
            p    = int'(m_cfg[i][15:0]);
            b    = int'(m_cfg[i][27:20]);
            if (wr && int'(a) == i) begin
                m_cfg[i]   = d & 32'h0FF3_FFFF;
                m_cnt[i]   = 0;
                m_edges[i] = 0;
                m_done[i]  = 1'b0;
                m_led[i]   = (d[17:16] == 2'd1);
            end else if (sync_now) begin
                m_cnt[i]   = 0;
                m_edges[i] = 0;
                m_done[i]  = 1'b0;
                if (mode >= 2) m_led[i] = 1'b0;
            end else if (tick_now && mode >= 2) begin
                if (mode == 3 && m_done[i]) begin
                    m_led[i] = 1'b0;
                end else if (mode == 3 && b == 0) begin
                    m_done[i] = 1'b1;
                    m_led[i]  = 1'b0;
                end else if (p == 0) begin
                    m_led[i] = 1'b0;
                    m_cnt[i] = 0;
                end else if (m_cnt[i] == p - 1) begin
                    m_cnt[i] = 0;
                    m_led[i] = !m_led[i];
                    if (mode == 3) begin
                        m_edges[i]++;
                        if (m_edges[i] == 2 * b) begin
                            m_done[i] = 1'b1;
                            m_led[i]  = 1'b0;
                        end
                    end
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    // One clock of stimulus: drive the bus, queue what the DUT must show this cycle, advance the model.
    task automatic step(input bit rst, input bit c, input bit r, input bit w,
                        input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset       = rst;
        bus.cs      = c;
        bus.read    = r;
        bus.write   = w;
        bus.addr    = a;
        bus.wr_data = d;
        if (rst) model_reset();
        exp_dout_q.push_back(model_dout());
        if (c && r) begin
            exp_rd_q.push_back(model_read(a));
            exp_addr_q.push_back(a);
        end
        if (!rst) model_edge(c && w, a, d);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b1, 5'(a), d);
    endtask

    task automatic rd(input int a);
        step(1'b0, 1'b1, 1'b1, 1'b0, 5'(a), 32'h0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic hold_reset(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    // Monitor: compares dout every cycle and rd_data whenever a read is presented.
    always @(negedge clk) begin
        if (exp_dout_q.size() > 0) check("dout", 32'(dout), exp_dout_q.pop_front());
        if (bus.cs === 1'b1 && bus.read === 1'b1) begin
            if (exp_rd_q.size() > 0) begin
                logic [4:0] a;
                a = exp_addr_q.pop_front();
                check($sformatf("rd_data[%0d]", a), bus.rd_data, exp_rd_q.pop_front());
            end else begin
                check("rd_data unexpected read", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        bus.cs      = 1'b0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
        model_reset();

        // Reset state and readback of every address.
        hold_reset(3);
        for (int a = 0; a < 32; a++) rd(a);

        // Free-running blink on channel 0.
        wr(16, 32'h1);
        wr(0, mk_cfg(2, 3, 0));
        idle(30);

        // Burst on channel 1, then rewrite to clear its done flag.
        wr(1, mk_cfg(3, 1, 2));
        idle(14);
        rd(17);
        wr(1, mk_cfg(3, 1, 2));
        rd(17);

        // Static ON with junk in unused bits, BLINK with zero period.
        wr(2, mk_cfg(1, 5, 7) | 32'hF00C_0000);
        wr(3, mk_cfg(2, 0, 0));
        idle(6);
        rd(2);
        rd(3);

        // Two blinkers out of phase, then realigned by sync.
        wr(0, mk_cfg(2, 2, 0));
        idle(3);
        wr(1, mk_cfg(2, 2, 0));
        idle(5);
        wr(16, 32'h3);
        idle(12);
        rd(16);

        // Freeze with enable = 0, then reset in the middle of a burst.
        wr(16, 32'h0);
        idle(8);
        wr(16, 32'h1);
        wr(1, mk_cfg(3, 2, 3));
        idle(5);
        hold_reset(2);
        rd(17);
        idle(2);

        // Randomised traffic.
        wr(16, 32'h1);
        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 40) begin
                idle(1);
            end else if (sel < 60) begin
                wr($urandom_range(0, N_CH - 1),
                   mk_cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3))
                   | ($urandom() & 32'hF00C_0000));
            end else if (sel < 70) begin
                logic [31:0] d;
                d    = $urandom();
                d[0] = ($urandom_range(0, 4) != 0);
                d[1] = ($urandom_range(0, 3) == 0);
                wr(16, d);
            end else if (sel < 90) begin
                rd($urandom_range(0, 31));
            end else if (sel < 97) begin
                wr($urandom_range(0, 31), $urandom());
            end else begin
                hold_reset($urandom_range(1, 2));
            end
        end

        idle(1);
        @(negedge clk);
        #1;
        check("rd queue drained", 32'(exp_rd_q.size()), 32'd0);
        check("dout queue drained", 32'(exp_dout_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
